// File: rtl/data_path_pkg.sv
// data_path_pkg
//   Shared constants for the single-cycle MIPS execution datapath:
//   ALU operation codes, instruction field bit positions and default sizes.
package data_path_pkg;

    // ALU operation codes presented on ALUCtrl
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Instruction field positions
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Default sizes
    localparam int DATA_W_DEF    = 32;
    localparam int MEM_WORDS_DEF = 128;
    localparam int REG_AW        = 5;

endpackage

// File: rtl/data_path_if.sv
// data_path_if
//   Bundles the instruction word, decoded control strobes and datapath
//   results between the CPU control path (master) and data_path (slave).
//   Optional debug read port present when DATA_PATH_DBG_EN is defined.
//   Signals: instruction, RegDst, ALUSrc, ALUCtrl, MemRead, MemWrite,
//            MemtoReg, RegWrite (master->slave); alu_result, alu_zero,
//            wb_data (slave->master); dbg_reg_addr / dbg_reg_data (debug).
interface data_path_if #(parameter int DATA_W = 32);
    logic [31:0]       instruction;
    logic              RegDst;
    logic              ALUSrc;
    logic [3:0]        ALUCtrl;
    logic              MemRead;
    logic              MemWrite;
    logic              MemtoReg;
    logic              RegWrite;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic [DATA_W-1:0] wb_data;
`ifdef DATA_PATH_DBG_EN
    logic [4:0]        dbg_reg_addr;
    logic [DATA_W-1:0] dbg_reg_data;
`endif

    modport master (
        output instruction, RegDst, ALUSrc, ALUCtrl,
        output MemRead, MemWrite, MemtoReg, RegWrite,
`ifdef DATA_PATH_DBG_EN
        output dbg_reg_addr,
        input  dbg_reg_data,
`endif
        input  alu_result, alu_zero, wb_data
    );

    modport slave (
        input  instruction, RegDst, ALUSrc, ALUCtrl,
        input  MemRead, MemWrite, MemtoReg, RegWrite,
`ifdef DATA_PATH_DBG_EN
        input  dbg_reg_addr,
        output dbg_reg_data,
`endif
        output alu_result, alu_zero, wb_data
    );
endinterface

// File: rtl/data_path_reg_file.sv
// data_path_reg_file
//   32 x DATA_W register file: two combinational read ports (three when
//   DATA_PATH_DBG_EN is defined), one synchronous write port, asynchronous
//   active-low clear. R0 always reads zero and ignores writes.
//   Ports: clk, rst_n, ra_addr/ra_data, rb_addr/rb_data,
//          [dbg_addr/dbg_data], we, wr_addr, wr_data.
module data_path_reg_file
    import data_path_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
`ifdef DATA_PATH_DBG_EN
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
`endif
    input  logic              we,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);
    localparam int NREGS = 32;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Next-state: single write port, writes to R0 dropped
    always_comb begin
        regs_d = regs_q;
        if (we && (wr_addr != 5'd0)) begin
            regs_d[wr_addr] = wr_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register array with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: {DATA_W{1'b0}}};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: R0 forced to zero
    assign ra_data = (ra_addr == 5'd0) ? {DATA_W{1'b0}} : regs_q[ra_addr];
    assign rb_data = (rb_addr == 5'd0) ? {DATA_W{1'b0}} : regs_q[rb_addr];
`ifdef DATA_PATH_DBG_EN
    assign dbg_data = (dbg_addr == 5'd0) ? {DATA_W{1'b0}} : regs_q[dbg_addr];
`endif

endmodule

// File: rtl/data_path.sv
// data_path
//   Single-cycle MIPS execution datapath: register file, ALU, MEM_WORDS-deep
//   data memory and writeback mux. All outputs are combinational from the
//   instruction/controls; register and memory updates land on the next
//   rising clock edge. reset is asynchronous active-low and clears all
//   registers and memory words.
//   Ports: clock, reset, dp (data_path_if.slave: instruction + controls in,
//          alu_result / alu_zero / wb_data out).
//   Build option DATA_PATH_DBG_EN adds dbg_reg_addr / dbg_reg_data to dp,
//   a third combinational register read port.
module data_path
    import data_path_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic       clock,
    input  logic       reset,
    data_path_if.slave dp
);
    localparam int MEM_AW = $clog2(MEM_WORDS);

    logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr, dest_addr;
    logic [DATA_W-1:0] rs_data, rt_data, imm_ext, alu_b, alu_res;
    logic [DATA_W-1:0] mem_rdata, wb;
    logic [MEM_AW-1:0] mem_addr;

    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    logic [DATA_W-1:0] mem_d [MEM_WORDS];

    assign rs_addr = dp.instruction[RS_MSB:RS_LSB];
    assign rt_addr = dp.instruction[RT_MSB:RT_LSB];
    assign rd_addr = dp.instruction[RD_MSB:RD_LSB];
    assign imm_ext = {{(DATA_W-16){dp.instruction[IMM_MSB]}},
                      dp.instruction[IMM_MSB:IMM_LSB]};

    data_path_reg_file #(.DATA_W(DATA_W)) u_reg_file (
        .clk      (clock),
        .rst_n    (reset),
        .ra_addr  (rs_addr),
        .rb_addr  (rt_addr),
`ifdef DATA_PATH_DBG_EN
        .dbg_addr (dp.dbg_reg_addr),
        .dbg_data (dp.dbg_reg_data),
`endif
        .we       (dp.RegWrite),
        .wr_addr  (dest_addr),
        .wr_data  (wb),
        .ra_data  (rs_data),
        .rb_data  (rt_data)
    );

    // Destination register and ALU B operand selection
    always_comb begin
        dest_addr = rt_addr;
        alu_b     = rt_data;
        if (dp.RegDst) begin
            dest_addr = rd_addr;
        end else begin
            dest_addr = rt_addr;
        end
        if (dp.ALUSrc) begin
            alu_b = imm_ext;
        end else begin
            alu_b = rt_data;
        end
    end

    // ALU: arithmetic wraps, unknown codes produce zero
    always_comb begin
        alu_res = {DATA_W{1'b0}};
        case (dp.ALUCtrl)
            ALU_AND: alu_res = rs_data & alu_b;
            ALU_OR:  alu_res = rs_data | alu_b;
            ALU_ADD: alu_res = rs_data + alu_b;
            ALU_SUB: alu_res = rs_data - alu_b;
            ALU_SLT: alu_res = ($signed(rs_data) < $signed(alu_b))
                               ? {{(DATA_W-1){1'b0}}, 1'b1} : {DATA_W{1'b0}};
            ALU_NOR: alu_res = ~(rs_data | alu_b);
            default: alu_res = {DATA_W{1'b0}};
        endcase
    end

    // Word address: byte offset and bits above the memory depth are dropped
    assign mem_addr = alu_res[MEM_AW+1:2];

    // Memory read and writeback select; read always sees pre-edge contents
    always_comb begin
        mem_rdata = {DATA_W{1'b0}};
        wb        = alu_res;
        if (dp.MemRead) begin
            mem_rdata = mem_q[mem_addr];
        end else begin
            mem_rdata = {DATA_W{1'b0}};
        end
        if (dp.MemtoReg) begin
            wb = mem_rdata;
        end else begin
            wb = alu_res;
        end
    end

    // Data memory next-state
    always_comb begin
        mem_d = mem_q;
        if (dp.MemWrite) begin
            mem_d[mem_addr] = rt_data;
        end else begin
            mem_d = mem_q;
        end
    end

    // Data memory storage with asynchronous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: {DATA_W{1'b0}}};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dp.alu_result = alu_res;
    assign dp.alu_zero   = (alu_res == {DATA_W{1'b0}});
    assign dp.wb_data    = wb;

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;
    import data_path_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] m_r   [32];
    logic [31:0] m_mem [128];

    data_path_if #(.DATA_W(32)) dp ();

    data_path #(.DATA_W(32), .MEM_WORDS(128)) dut (
        .clock (clock),
        .reset (reset),
        .dp    (dp)
    );

`ifdef DATA_PATH_DBG_EN
    assign dp.dbg_reg_addr = 5'd0;
`endif

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd);
        mk_r = {6'd0, rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input int rs, input int rt, input logic [15:0] imm);
        mk_i = {6'd8, rs[4:0], rt[4:0], imm};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic regdst, input logic alusrc,
                         input logic [3:0] op, input logic mrd, input logic mwr,
                         input logic m2r, input logic rwr);
        dp.instruction = ins;
        dp.RegDst      = regdst;
        dp.ALUSrc      = alusrc;
        dp.ALUCtrl     = op;
        dp.MemRead     = mrd;
        dp.MemWrite    = mwr;
        dp.MemtoReg    = m2r;
        dp.RegWrite    = rwr;
    endtask

    // Reference ALU from the operation table
    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'b0000: m_alu = a & b;
            4'b0001: m_alu = a | b;
            4'b0010: m_alu = a + b;
            4'b0110: m_alu = a - b;
            4'b0111: m_alu = (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            4'b1100: m_alu = ~(a | b);
            default: m_alu = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_alu();
        logic [31:0] a, b, imm;
        imm = {{16{dp.instruction[15]}}, dp.instruction[15:0]};
        a = m_r[dp.instruction[25:21]];
        b = dp.ALUSrc ? imm : m_r[dp.instruction[20:16]];
        exp_alu = m_alu(dp.ALUCtrl, a, b);
    endfunction

    function automatic logic [31:0] exp_wb();
        logic [31:0] res;
        res = exp_alu();
        if (dp.MemtoReg) exp_wb = dp.MemRead ? m_mem[(res / 4) % 128] : 32'd0;
        else             exp_wb = res;
    endfunction

    // Apply one clock edge and update the model with the architectural effect
    task automatic commit();
        logic [31:0] wbv, res, rtv;
        int dst;
        res = exp_alu();
        wbv = exp_wb();
        rtv = m_r[dp.instruction[20:16]];
        dst = dp.RegDst ? int'(dp.instruction[15:11]) : int'(dp.instruction[20:16]);
        @(posedge clock);
        if (dp.MemWrite) m_mem[(res / 4) % 128] = rtv;
        if (dp.RegWrite && dst != 0) m_r[dst] = wbv;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++)  m_r[i] = 32'd0;
        for (int i = 0; i < 128; i++) m_mem[i] = 32'd0;
    endtask

    task automatic show_reg(input int i);
        drive(mk_r(i, 0, 0), 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
    endtask

    task automatic show_mem(input int i);
        logic [15:0] off;
        off = 16'(i * 4);
        drive(mk_i(0, 0, off), 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        drive(mk_r(0, 0, 0), 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_model();
        #12;
        total++;
        if (dp.alu_result !== 32'd0 || dp.alu_zero !== 1'b1) begin
            bad++;
            $display("FAIL reset_add_r0 got=%h/%b exp=0/1", dp.alu_result, dp.alu_zero);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        drive(mk_i(0, 5, 16'd123), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        commit();
        drive(mk_i(0, 5, 16'd8), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
        commit();
        // mid-cycle reset pulse, checked before any further clock edge
        #2;
        reset = 1'b0;
        clear_model();
        show_reg(5);
        total++;
        if (dp.alu_result !== 32'd0) begin
            bad++;
            $display("FAIL reset_r5_noedge got=%h exp=0", dp.alu_result);
        end
        show_mem(2);
        total++;
        if (dp.wb_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_mem2_noedge got=%h exp=0", dp.wb_data);
        end
        // writes requested while reset is low must not land
        drive(mk_i(0, 6, 16'h0055), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clock); @(posedge clock); #1;
        for (int i = 0; i < 32; i++) begin
            show_reg(i);
            total++;
            if (dp.alu_result !== 32'd0) begin
                bad++;
                $display("FAIL reset_reg[%0d] got=%h exp=0", i, dp.alu_result);
            end
        end
        for (int i = 0; i < 128; i++) begin
            show_mem(i);
            total++;
            if (dp.wb_data !== 32'd0) begin
                bad++;
                $display("FAIL reset_mem[%0d] got=%h exp=0", i, dp.wb_data);
            end
        end
        drive(mk_r(0, 0, 0), 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_addi();
        drive(mk_i(0, 1, 16'hFFFB), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        total++;
        if (dp.alu_result !== 32'hFFFF_FFFB) begin
            bad++;
            $display("FAIL addi_alu got=%h exp=fffffffb", dp.alu_result);
        end
        commit();
        show_reg(1);
        total++;
        if (dp.alu_result !== 32'hFFFF_FFFB) begin
            bad++;
            $display("FAIL addi_r1 got=%h exp=fffffffb", dp.alu_result);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  ops [6];
        logic [31:0] exp3 [6];
        ops  = '{ALU_SUB, ALU_SLT, ALU_AND, ALU_OR, ALU_ADD, ALU_NOR};
        exp3 = '{32'd2, 32'd0, 32'd5, 32'd7, 32'd12, 32'hFFFF_FFF8};
        drive(mk_i(0, 1, 16'd7), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        commit();
        drive(mk_i(0, 2, 16'd5), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        commit();
        for (int k = 0; k < 6; k++) begin
            drive(mk_r(1, 2, 3), 1'b1, 1'b0, ops[k], 1'b0, 1'b0, 1'b0, 1'b1);
            commit();
            show_reg(3);
            total++;
            if (dp.alu_result !== exp3[k]) begin
                bad++;
                $display("FAIL rtype_op%0d_r3 got=%h exp=%h", k, dp.alu_result, exp3[k]);
            end
        end
        drive(mk_r(2, 1, 3), 1'b1, 1'b0, ALU_SLT, 1'b0, 1'b0, 1'b0, 1'b1);
        commit();
        show_reg(3);
        total++;
        if (dp.alu_result !== 32'd1) begin
            bad++;
            $display("FAIL rtype_slt_swap got=%h exp=1", dp.alu_result);
        end
        drive(mk_r(0, 0, 3), 1'b1, 1'b0, ALU_NOR, 1'b0, 1'b0, 1'b0, 1'b1);
        commit();
        show_reg(3);
        total++;
        if (dp.alu_result !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL rtype_nor_zero got=%h exp=ffffffff", dp.alu_result);
        end
    endtask

    task automatic test_sw_lw();
        drive(mk_i(0, 1, 16'd8), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        commit();
        drive(mk_i(0, 2, 16'hDEAE), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        commit();
        repeat (16) begin
            drive(mk_r(2, 2, 2), 1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
            commit();
        end
        drive(mk_i(2, 2, 16'hBEEF), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        commit();
        show_reg(2);
        total++;
        if (dp.alu_result !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL build_r2 got=%h exp=deadbeef", dp.alu_result);
        end
        drive(mk_i(1, 2, 16'd4), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
        commit();
        drive(mk_i(1, 4, 16'd4), 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        total++;
        if (dp.wb_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL lw_wb got=%h exp=deadbeef", dp.wb_data);
        end
        commit();
        show_reg(4);
        total++;
        if (dp.alu_result !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL lw_r4 got=%h exp=deadbeef", dp.alu_result);
        end
    endtask

    task automatic test_boundaries();
        drive(mk_i(0, 0, 16'd5), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        commit();
        show_reg(0);
        total++;
        if (dp.alu_result !== 32'd0 || dp.alu_zero !== 1'b1) begin
            bad++;
            $display("FAIL r0_write got=%h/%b exp=0/1", dp.alu_result, dp.alu_zero);
        end
        drive(mk_i(0, 2, 16'd0), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
        commit();
        drive(mk_i(0, 7, 16'h0200), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        commit();
        drive(mk_i(7, 9, 16'd0), 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (dp.wb_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL alias_0x200 got=%h exp=deadbeef", dp.wb_data);
        end
        drive(mk_i(7, 9, 16'd3), 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (dp.wb_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL alias_0x203 got=%h exp=deadbeef", dp.wb_data);
        end
        drive(mk_i(7, 9, 16'd0), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (dp.wb_data !== 32'd0) begin
            bad++;
            $display("FAIL memread_off_wb got=%h exp=0", dp.wb_data);
        end
    endtask

    task automatic test_back_to_back();
        drive(mk_i(0, 1, 16'd20), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
        commit();
        drive(mk_i(0, 2, 16'd20), 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        total++;
        if (dp.wb_data !== 32'd8) begin
            bad++;
            $display("FAIL rw_same_old got=%h exp=8", dp.wb_data);
        end
        commit();
        drive(mk_i(0, 2, 16'd20), 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (dp.wb_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL rw_same_new got=%h exp=deadbeef", dp.wb_data);
        end
        drive(mk_i(1, 1, 16'd1), 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        total++;
        if (dp.alu_result !== 32'd9) begin
            bad++;
            $display("FAIL no_bypass got=%h exp=9", dp.alu_result);
        end
        commit();
        show_reg(1);
        total++;
        if (dp.alu_result !== 32'd9) begin
            bad++;
            $display("FAIL reg_inc got=%h exp=9", dp.alu_result);
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [7];
        logic [31:0] ea, ew;
        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, 4'b0000};
        for (int n = 0; n < 300; n++) begin
            ops[6] = 4'($urandom_range(15, 0));
            drive($urandom, 1'($urandom), 1'($urandom), ops[$urandom_range(6, 0)],
                  1'($urandom), 1'($urandom_range(3, 0) == 0), 1'($urandom), 1'($urandom));
            #1;
            ea = exp_alu();
            ew = exp_wb();
            total++;
            if (dp.alu_result !== ea || dp.alu_zero !== (ea == 32'd0) || dp.wb_data !== ew) begin
                bad++;
                $display("FAIL rand%0d got=%h/%b/%h exp=%h/%b/%h", n, dp.alu_result,
                         dp.alu_zero, dp.wb_data, ea, (ea == 32'd0), ew);
            end
            commit();
        end
        for (int i = 0; i < 32; i++) begin
            show_reg(i);
            total++;
            if (dp.alu_result !== m_r[i]) begin
                bad++;
                $display("FAIL rand_reg[%0d] got=%h exp=%h", i, dp.alu_result, m_r[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_sw_lw();
        test_boundaries();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
